// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command into a single SETUP -> ACCESS
// transfer and reports read data, slave error and timeout on a response strobe.
module apb_master #(
  parameter int DWIDTH  = 8,
  parameter int AWIDTH  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [AWIDTH-1:0] PADDR,
  output logic [DWIDTH-1:0] PWDATA,
  input  logic [DWIDTH-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic [1:0]        dbg_state_o
);

  // Handshake: a command is taken on an edge where cmd_valid && cmd_ready.
  // cmd_ready is a pure decode of the registered state (high only in IDLE).
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  // A zero-width counter is illegal, so a disabled timeout keeps one bit.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] WAIT_MAX  = {CW{1'b1}};

  logic [1:0]        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [AWIDTH-1:0] paddr_q, paddr_d;
  logic [DWIDTH-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic [CW-1:0]     wait_q, wait_d;

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    rdata_d       = rdata_q;
    wait_d        = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        wait_d    = '0;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          if (!pwrite_q) rdata_d = PRDATA;
          state_d       = ST_IDLE;
        end else begin
          if (wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;
          // wait_q counts earlier low cycles, so this edge is the TIMEOUT-th.
          if ((TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            state_d       = ST_IDLE;
          end
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= ST_IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rdata_q       <= '0;
      wait_q        <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      rdata_q       <= rdata_d;
      wait_q        <= wait_d;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester (initiator) that drives PSEL/PENABLE/PADDR/PWRITE/PWDATA toward the team's APB responder registers.
- Turns a simple valid/ready command interface into one APB transfer at a time, following the SETUP -> ACCESS protocol.
- Returns read data, slave error and timeout status on a one-cycle response strobe.
- Sits between the test/control logic and the APB register slaves.

Parameters:
- DWIDTH, 8, width of PWDATA/PRDATA and of the command/response data.
- AWIDTH, 8, width of PADDR and cmd_addr.
- TIMEOUT, 16, number of consecutive ACCESS cycles with PREADY low before the transfer is aborted; 0 disables the timeout.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on an edge where cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AWIDTH  transfer address.
- cmd_wdata  in  DWIDTH  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse at transfer completion.
- rsp_rdata  out  DWIDTH  captured PRDATA of the last completed read.
- rsp_err  out  1  PSLVERR of the completed transfer, or 1 on timeout; valid with rsp_valid.
- rsp_timeout  out  1  1 if the transfer was aborted by timeout; valid with rsp_valid.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR  out  AWIDTH  APB address.
- PWDATA  out  DWIDTH  APB write data.
- PRDATA  in  DWIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Reset (PRESET=1 at an edge): state IDLE.
  - PSEL, PENABLE, PWRITE, rsp_valid, rsp_err and rsp_timeout = 0.
  - PADDR, PWDATA, rsp_rdata and the wait counter = 0.
  - Reset wins over every other event.
- FSM has three states: IDLE, SETUP, ACCESS.
- cmd_ready = (state == IDLE); it is a registered-state decode, with no combinational path from cmd_valid.
- IDLE: on accept, register PADDR=cmd_addr, PWRITE=cmd_write, PWDATA=cmd_wdata (PWDATA loaded on reads too), and set PSEL=1, PENABLE=0; go to SETUP.
- SETUP: lasts exactly one cycle. At the next edge PENABLE=1, clear the wait counter, go to ACCESS.
- ACCESS, edge with PREADY=1:
  - Drive PSEL=0, PENABLE=0 and pulse rsp_valid=1 for one cycle.
  - rsp_err=PSLVERR, rsp_timeout=0.
  - On a read, rsp_rdata=PRDATA; on a write, rsp_rdata holds its value.
  - Go to IDLE.
- ACCESS, edge with PREADY=0:
  - Increment the wait counter, which saturates and is sized clog2(TIMEOUT+1).
  - If TIMEOUT != 0 and this is the TIMEOUT-th consecutive low cycle: abort. Drive PSEL=0, PENABLE=0, rsp_valid=1, rsp_err=1, rsp_timeout=1; rsp_rdata is unchanged; go to IDLE.
- PADDR, PWRITE and PWDATA stay stable from SETUP through the end of ACCESS, and keep their values after the transfer until the next accept.
- PREADY, PSLVERR and PRDATA are ignored outside ACCESS.
- Between edges where rsp_valid=1, rsp_err and rsp_timeout hold their last values.
- No command buffering. cmd_valid while busy is simply not accepted; the command must be held until cmd_ready.
- Latency: accept at edge N gives SETUP during cycle N..N+1 and ACCESS from edge N+1. With zero waits, rsp_valid is high after edge N+2. Minimum issue period is 3 cycles (IDLE, SETUP, ACCESS), so back-to-back transfers have exactly one idle bus cycle between them.
- Reset mid-transfer: the bus is idle after that edge and no rsp_valid is produced for the aborted transfer.

Test Plan:
- Write, no wait: cmd_write=1, addr=0x12, wdata=0xA5 -> PSEL high one cycle with PENABLE=0, then one cycle with PENABLE=1 and PADDR=0x12, PWDATA=0xA5, PWRITE=1; rsp_valid one cycle later, rsp_err=0.
- Read, 2 wait states: PRDATA=0x3C, PREADY low 2 ACCESS cycles then high -> ACCESS lasts 3 cycles, rsp_rdata=0x3C, rsp_err=0, address stable throughout.
- Slave error: read with PSLVERR=1 and PREADY=1 -> rsp_valid=1, rsp_err=1, rsp_timeout=0, rsp_rdata=PRDATA.
- Timeout: TIMEOUT=4, PREADY held low -> exactly 4 ACCESS cycles, then rsp_valid=1, rsp_err=1, rsp_timeout=1, PSEL/PENABLE=0, rsp_rdata unchanged, cmd_ready=1 next cycle.
- Reset mid-ACCESS: PRESET=1 while PENABLE=1 -> next cycle PSEL=PENABLE=rsp_valid=0, PADDR=0, cmd_ready=1.
- Back-to-back: cmd_valid held high with two commands (write 0x01@0x00, then read @0x01) -> second PSEL rises exactly one idle cycle after the first rsp_valid; cmd_ready low throughout each transfer.
